// File: rtl/bp_lite_to_stream_if.sv
// Handshake bundle between a Lite master, the bp_lite_to_stream converter and its stream consumer.
// Signal suffixes are written from the converter's point of view.
interface bp_lite_to_stream_if #(
  parameter int HDR_W = 47,
  parameter int IN_W  = 512,
  parameter int OUT_W = 64
);
  logic [HDR_W+IN_W-1:0] mem_i;
  logic                  mem_v_i;
  logic                  mem_ready_o;
  logic [HDR_W-1:0]      mem_header_o;
  logic [OUT_W-1:0]      mem_data_o;
  logic                  mem_v_o;
  logic                  mem_ready_i;
  logic                  mem_last_o;

  modport slave (
    input  mem_i, mem_v_i, mem_ready_i,
    output mem_ready_o, mem_header_o, mem_data_o, mem_v_o, mem_last_o
  );

  modport master (
    output mem_i, mem_v_i, mem_ready_i,
    input  mem_ready_o, mem_header_o, mem_data_o, mem_v_o, mem_last_o
  );
endinterface

// File: rtl/bp_lite_to_stream.sv
// BedRock Lite -> Stream converter: buffers one {header, wide data} message and replays it as
// narrow beats, low-order first, accepting the next message in the cycle the last beat leaves.
module bp_lite_to_stream #(
  parameter int          paddr_width_p    = 40,
  parameter int          in_data_width_p  = 512,
  parameter int          out_data_width_p = 64,
  parameter logic [15:0] payload_mask_p   = 16'h0000
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_lite_to_stream_if.slave    bus
);
  // Header layout: {addr, size, msg_type}; size encodes 2**size bytes.
  localparam int          HDR_W      = paddr_width_p + 7;
  localparam int unsigned R          = in_data_width_p / out_data_width_p;
  localparam int          CNT_W      = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned BEAT_BYTES = out_data_width_p / 8;

  if (in_data_width_p <= out_data_width_p) begin : g_bad_ratio
    $error("in_data_width_p must exceed out_data_width_p");
  end
  if (in_data_width_p % out_data_width_p != 0) begin : g_bad_mult
    $error("in_data_width_p must be a multiple of out_data_width_p");
  end

  // Beats-minus-one for a message, saturated to [0, R-1]; non-payload types always send one beat.
  function automatic logic [CNT_W-1:0] f_sat_beats_m1(input logic [3:0] t, input logic [2:0] s);
    logic [31:0] q;
    q = (32'd1 << s) / BEAT_BYTES;
    if (!payload_mask_p[t] || q == 32'd0) return '0;
    if (q >= R) return CNT_W'(R - 1);
    return CNT_W'(q - 32'd1);
  endfunction

  logic                       r_vld_p0;
  logic [CNT_W-1:0]           r_cnt_p0;
  logic [CNT_W-1:0]           r_nm1_p0;
  logic [HDR_W-1:0]           r_hdr_p0;
  logic [in_data_width_p-1:0] r_data_p0;

  logic [R-1:0][out_data_width_p-1:0] w_beats;
  logic [3:0] w_type;
  logic [2:0] w_size;
  logic       w_vld;
  logic       w_last;
  logic       w_ready;
  logic       w_in_fire;
  logic       w_out_fire;

  assign w_type     = bus.mem_i[in_data_width_p +: 4];
  assign w_size     = bus.mem_i[in_data_width_p + 4 +: 3];
  assign w_beats    = r_data_p0;
  assign w_vld      = r_vld_p0 & reset_n_i;
  assign w_last     = (r_cnt_p0 == r_nm1_p0);
  assign w_out_fire = w_vld & bus.mem_ready_i;
  assign w_ready    = reset_n_i & (~r_vld_p0 | (w_out_fire & w_last));
  assign w_in_fire  = bus.mem_v_i & w_ready;

  assign bus.mem_ready_o  = w_ready;
  assign bus.mem_v_o      = w_vld;
  assign bus.mem_last_o   = w_vld & w_last;
  assign bus.mem_header_o = r_hdr_p0;
  assign bus.mem_data_o   = w_beats[r_cnt_p0];

  // p0: message buffer control (full flag and beat counter)
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_vld_p0 <= 1'b0;
      r_cnt_p0 <= '0;
    end else if (w_out_fire) begin
      if (w_last) begin
        r_cnt_p0 <= '0;
        r_vld_p0 <= w_in_fire;
      end else begin
        r_cnt_p0 <= r_cnt_p0 + 1'b1;
      end
    end else if (w_in_fire) begin
      r_vld_p0 <= 1'b1;
      r_cnt_p0 <= '0;
    end
  end

  // p0: message payload, loaded on accept only
  always_ff @(posedge clk_i) begin
    if (w_in_fire) begin
      r_hdr_p0  <= bus.mem_i[in_data_width_p +: HDR_W];
      r_data_p0 <= bus.mem_i[in_data_width_p-1:0];
      r_nm1_p0  <= f_sat_beats_m1(w_type, w_size);
    end
  end
endmodule

// File: tb/tb_bp_lite_to_stream.sv
// Directed, table-driven bench for bp_lite_to_stream at 512/64 with write types carrying payload.
module tb_bp_lite_to_stream;
  localparam int HDR_W = 47;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  bp_lite_to_stream_if #(.HDR_W(HDR_W), .IN_W(512), .OUT_W(64)) bus ();

  bp_lite_to_stream #(
    .paddr_width_p(40), .in_data_width_p(512), .out_data_width_p(64),
    .payload_mask_p(16'h002A)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] t;
    logic [2:0] s;
    int         n;
    logic [7:0] base;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [7:0] base);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[k*8 +: 8] = base + 8'(k + 1);
    return d;
  endfunction

  function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                               input logic [39:0] a);
    return {a, s, t};
  endfunction

  task automatic exp_beat(input string tag, input logic [511:0] d, input logic [HDR_W-1:0] h,
                          input int k, input int n, input logic ri);
    logic lst;
    lst = (k == n - 1);
    chk($sformatf("%s.b%0d.v", tag, k),     64'(bus.mem_v_o), 64'd1);
    chk($sformatf("%s.b%0d.data", tag, k),  bus.mem_data_o, d[k*64 +: 64]);
    chk($sformatf("%s.b%0d.last", tag, k),  64'(bus.mem_last_o), 64'(lst));
    chk($sformatf("%s.b%0d.hdr", tag, k),   64'(bus.mem_header_o), 64'(h));
    chk($sformatf("%s.b%0d.rdy", tag, k),   64'(bus.mem_ready_o), 64'(lst & ri));
  endtask

  task automatic offer(input logic [HDR_W-1:0] h, input logic [511:0] d, input string tag);
    @(negedge clk);
    bus.mem_i = {h, d};
    bus.mem_v_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1 chk({tag, ".acc_rdy"}, 64'(bus.mem_ready_o), 64'd1);
    @(posedge clk);
  endtask

  task automatic send(input logic [3:0] t, input logic [2:0] s, input logic [7:0] base,
                      input int n, input string tag);
    logic [511:0]     d;
    logic [HDR_W-1:0] h;
    d = mk_data(base);
    h = mk_hdr(t, s, 40'h12_3456_7000 + 40'(base));
    offer(h, d, tag);
    @(negedge clk);
    bus.mem_v_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1 exp_beat(tag, d, h, k, n, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    #1 chk({tag, ".idle_v"}, 64'(bus.mem_v_o), 64'd0);
  endtask

  vec_t             tbl [9];
  logic [511:0]     dA, dB;
  logic [HDR_W-1:0] hA, hB;
  logic [3:0]       pat;
  int               kk, cc;

  initial begin
    // type: 0 rd, 1 wr, 3 uc_wr, 4 pre, 5 amo; size: 2**s bytes
    tbl[0] = '{4'd1, 3'd6, 8, 8'h00};
    tbl[1] = '{4'd0, 3'd6, 1, 8'h10};
    tbl[2] = '{4'd1, 3'd3, 1, 8'h20};
    tbl[3] = '{4'd1, 3'd4, 2, 8'h30};
    tbl[4] = '{4'd3, 3'd5, 4, 8'h40};
    tbl[5] = '{4'd1, 3'd7, 8, 8'h50};
    tbl[6] = '{4'd1, 3'd0, 1, 8'h60};
    tbl[7] = '{4'd5, 3'd2, 1, 8'h70};
    tbl[8] = '{4'd4, 3'd6, 1, 8'h80};

    rst_n = 1'b0;
    bus.mem_i = '0;
    bus.mem_v_i = 1'b0;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.rdy",  64'(bus.mem_ready_o), 64'd0);
    chk("rst.v",    64'(bus.mem_v_o), 64'd0);
    chk("rst.last", 64'(bus.mem_last_o), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst.rdy", 64'(bus.mem_ready_o), 64'd1);
    chk("post_rst.v",   64'(bus.mem_v_o), 64'd0);

    dA = mk_data(8'h00);
    chk("pattern.b0", dA[63:0], 64'h0807060504030201);
    chk("pattern.b7", dA[511:448], 64'h403f3e3d3c3b3a39);

    for (int i = 0; i < 9; i++)
      send(tbl[i].t, tbl[i].s, tbl[i].base, tbl[i].n, $sformatf("vec%0d", i));

    // Back-to-back 64B writes: B is taken on A's last beat with no idle cycle.
    dA = mk_data(8'h00);
    dB = mk_data(8'h80);
    hA = mk_hdr(4'd1, 3'd6, 40'h00_0000_1000);
    hB = mk_hdr(4'd1, 3'd6, 40'h00_0000_2000);
    offer(hA, dA, "b2b.A");
    @(negedge clk);
    bus.mem_i = {hB, dB};
    bus.mem_v_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1 exp_beat("b2b.A", dA, hA, k, 8, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.mem_v_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1 exp_beat("b2b.B", dB, hB, k, 8, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    #1 chk("b2b.idle_v", 64'(bus.mem_v_o), 64'd0);

    // Backpressure with ready pattern 1,0,0,1,...
    dA = mk_data(8'hA0);
    hA = mk_hdr(4'd1, 3'd6, 40'h00_0000_3000);
    pat = 4'b1001;
    offer(hA, dA, "stall");
    @(negedge clk);
    bus.mem_v_i = 1'b0;
    kk = 0;
    cc = 0;
    while (kk < 8 && cc < 40) begin
      if (cc > 0) @(negedge clk);
      bus.mem_ready_i = pat[cc % 4];
      #1 exp_beat("stall", dA, hA, kk, 8, pat[cc % 4]);
      @(posedge clk);
      if (pat[cc % 4]) kk++;
      cc++;
    end
    chk("stall.done", 64'(kk), 64'd8);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    #1 chk("stall.idle_v", 64'(bus.mem_v_o), 64'd0);

    // Reset after beat 3 drops the message; a following read starts from beat 0.
    dA = mk_data(8'hC0);
    hA = mk_hdr(4'd1, 3'd6, 40'h00_0000_4000);
    offer(hA, dA, "rstmid");
    @(negedge clk);
    bus.mem_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1 exp_beat("rstmid", dA, hA, k, 8, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid.low.v",   64'(bus.mem_v_o), 64'd0);
    chk("rstmid.low.rdy", 64'(bus.mem_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstmid.held.v",    64'(bus.mem_v_o), 64'd0);
    chk("rstmid.held.rdy",  64'(bus.mem_ready_o), 64'd0);
    chk("rstmid.held.last", 64'(bus.mem_last_o), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rstmid.rel.rdy", 64'(bus.mem_ready_o), 64'd1);
    chk("rstmid.rel.v",   64'(bus.mem_v_o), 64'd0);
    @(posedge clk);
    send(4'd0, 3'd6, 8'hE0, 1, "rstmid.rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
